// File: rtl/adder_frame_accumulator.sv
// ---------------------------------------------------------------------------
// adder_frame_accumulator
//
// Purpose:
//    Sums FRAME_LEN consecutive handshaked DATA_WIDTH-bit words into an
//    ACC_WIDTH-bit result. The result goes out on a handshaked port together
//    with a sticky overflow flag. After that the block clears itself for the
//    next frame. The addition is a ripple-carry chain built from FullAdder
//    cells, so it matches the adder stage upstream.
//
// Ports:
//    clk        in   sole clock, rising edge
//    rst        in   synchronous active-high reset
//    din_data   in   input word, unsigned
//    din_vld    in   input word valid
//    din_rd     out  ready to accept an input word (depends on state and rst only)
//    dout_data  out  frame sum mod 2^ACC_WIDTH (registered)
//    dout_ovf   out  set if any addition in the frame carried out (registered)
//    dout_vld   out  result valid (registered)
//    dout_rd    in   downstream ready
// ---------------------------------------------------------------------------

// Single-bit full adder cell, chained to form the accumulator's adder.
module FullAdder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   // Sum and carry-out of a one-bit addition.
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

module adder_frame_accumulator #(
   parameter int DATA_WIDTH = 4,
   parameter int ACC_WIDTH  = 8,
   parameter int FRAME_LEN  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] din_data,
   input  logic                  din_vld,
   output logic                  din_rd,
   output logic [ACC_WIDTH-1:0]  dout_data,
   output logic                  dout_ovf,
   output logic                  dout_vld,
   input  logic                  dout_rd
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);

   typedef enum logic [0:0] {
      ACCUM  = 1'b0,
      OUTPUT = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic                   ovf_q, ovf_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ACC_WIDTH-1:0]   dout_data_q, dout_data_d;
   logic                   dout_ovf_q, dout_ovf_d;
   logic                   dout_vld_q, dout_vld_d;

   logic [ACC_WIDTH-1:0]   addend;
   logic [ACC_WIDTH-1:0]   sum;
   logic [ACC_WIDTH:0]     carry;
   logic [CNT_W-1:0]       cntInc;
   logic                   inHs;
   logic                   outHs;

   // The incoming word is unsigned, so it is zero-extended to the
   // accumulator width before it reaches the adder chain.
   assign addend   = ACC_WIDTH'(din_data);
   assign carry[0] = 1'b0;

   // Ripple-carry chain. The carry out of the top cell is the overflow
   // for this one addition.
   for (genvar i = 0; i < ACC_WIDTH; i++) begin : gAdder
      FullAdder uFa (
         .a_i (acc_q[i]),
         .b_i (addend[i]),
         .c_i (carry[i]),
         .s_o (sum[i]),
         .c_o (carry[i+1])
      );
   end

   // din_rd depends on the state register and rst only, so upstream never
   // sees a combinational path from dout_rd or din_vld.
   assign din_rd = (state_q == ACCUM) && !rst;
   assign inHs   = din_vld && din_rd;
   assign outHs  = dout_vld_q && dout_rd;
   assign cntInc = cnt_q + CNT_W'(1);

   // Next-state logic. In ACCUM, each accepted word is added in. The word
   // that completes the frame also loads the output registers, so dout_vld
   // rises on the next edge. In OUTPUT, inputs are ignored and the result
   // holds until downstream takes it. The frame state is cleared on that
   // handshake. No word is accepted in the same cycle as the output
   // handshake.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      cnt_d       = cnt_q;
      dout_data_d = dout_data_q;
      dout_ovf_d  = dout_ovf_q;
      dout_vld_d  = dout_vld_q;
      unique case (state_q)
         ACCUM: begin
            if (inHs) begin
               acc_d = sum;
               ovf_d = ovf_q | carry[ACC_WIDTH];
               cnt_d = cntInc;
               if (cntInc == CNT_W'(FRAME_LEN)) begin
                  dout_data_d = sum;
                  dout_ovf_d  = ovf_q | carry[ACC_WIDTH];
                  dout_vld_d  = 1'b1;
                  state_d     = OUTPUT;
               end
            end
         end
         OUTPUT: begin
            if (outHs) begin
               acc_d      = '0;
               ovf_d      = 1'b0;
               cnt_d      = '0;
               dout_vld_d = 1'b0;
               state_d    = ACCUM;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   // State and output registers. Reset is synchronous and discards any
   // partial sum or pending result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         cnt_q       <= '0;
         dout_data_q <= '0;
         dout_ovf_q  <= 1'b0;
         dout_vld_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         cnt_q       <= cnt_d;
         dout_data_q <= dout_data_d;
         dout_ovf_q  <= dout_ovf_d;
         dout_vld_q  <= dout_vld_d;
      end
   end

   assign dout_data = dout_data_q;
   assign dout_ovf  = dout_ovf_q;
   assign dout_vld  = dout_vld_q;

endmodule

// File: tb/tb_adder_frame_accumulator.sv
// ---------------------------------------------------------------------------
// tb_adder_frame_accumulator
//
// Three instances run in lockstep on one shared input stream:
//    dut 0: DATA_WIDTH=4, ACC_WIDTH=8, FRAME_LEN=4 (defaults)
//    dut 1: DATA_WIDTH=4, ACC_WIDTH=5, FRAME_LEN=4 (wrap-around and overflow)
//    dut 2: DATA_WIDTH=4, ACC_WIDTH=8, FRAME_LEN=1
// Each instance has its own reference model. The model keeps a plain
// integer running total and a word count. A frame's result is the total
// mod 2^ACC_WIDTH. Overflow is set when the true total reaches 2^ACC_WIDTH.
// ---------------------------------------------------------------------------
module tb_adder_frame_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       dinVld;
   logic       doutRd;
   logic [3:0] dinData;

   logic       rdA, rdB, rdC;
   logic       vldA, vldB, vldC;
   logic       ovfA, ovfB, ovfC;
   logic [7:0] dataA, dataC;
   logic [4:0] dataB;

   int aw[3] = '{8, 5, 8};
   int fl[3] = '{4, 4, 1};

   int total[3];
   int cnt[3];
   int expData[3];
   bit expOvf[3];
   bit pending[3];

   int assertions = 0;
   int failures   = 0;

   int seqA[4]  = '{1, 2, 3, 4};
   int gapV[7]  = '{1, 0, 0, 1, 0, 1, 1};
   int gapD[7]  = '{5, 0, 0, 6, 0, 7, 8};
   int fl1D[3]  = '{3, 12, 0};

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   adder_frame_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(8), .FRAME_LEN(4)) dutA (
      .clk(clk), .rst(rst), .din_data(dinData), .din_vld(dinVld), .din_rd(rdA),
      .dout_data(dataA), .dout_ovf(ovfA), .dout_vld(vldA), .dout_rd(doutRd)
   );

   adder_frame_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(5), .FRAME_LEN(4)) dutB (
      .clk(clk), .rst(rst), .din_data(dinData), .din_vld(dinVld), .din_rd(rdB),
      .dout_data(dataB), .dout_ovf(ovfB), .dout_vld(vldB), .dout_rd(doutRd)
   );

   adder_frame_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(8), .FRAME_LEN(1)) dutC (
      .clk(clk), .rst(rst), .din_data(dinData), .din_vld(dinVld), .din_rd(rdC),
      .dout_data(dataC), .dout_ovf(ovfC), .dout_vld(vldC), .dout_rd(doutRd)
   );

   // Select one instance's output by index. Outputs are zero-extended and
   // keep any X bits.
   function automatic logic [31:0] rdOf(input int k);
      case (k)
         0:       return 32'(rdA);
         1:       return 32'(rdB);
         default: return 32'(rdC);
      endcase
   endfunction

   function automatic logic [31:0] vldOf(input int k);
      case (k)
         0:       return 32'(vldA);
         1:       return 32'(vldB);
         default: return 32'(vldC);
      endcase
   endfunction

   function automatic logic [31:0] ovfOf(input int k);
      case (k)
         0:       return 32'(ovfA);
         1:       return 32'(ovfB);
         default: return 32'(ovfC);
      endcase
   endfunction

   function automatic logic [31:0] dataOf(input int k);
      case (k)
         0:       return 32'(dataA);
         1:       return 32'(dataB);
         default: return 32'(dataC);
      endcase
   endfunction

   // One comparison: counts it, and on a miss counts the failure and reports it.
   task automatic checkOutput(input string tag, input int k,
                              input logic [31:0] observed, input logic [31:0] expected);
      assertions++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s dut%0d observed=%0h expected=%0h", tag, k, observed, expected);
      end
   endtask

   // Drive one cycle of inputs away from the active edge. Check din_rd before
   // the edge, advance every model, and check the registered outputs just
   // after the edge.
   task automatic applyStimulus(input bit r, input bit v, input int d, input bit rdy);
      @(negedge clk);
      rst     = r;
      dinVld  = v;
      dinData = d[3:0];
      doutRd  = rdy;
      #1;
      for (int k = 0; k < 3; k++) begin
         checkOutput("din_rd", k, rdOf(k), 32'(!r && !pending[k]));
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         if (r) begin
            total[k]   = 0;
            cnt[k]     = 0;
            pending[k] = 1'b0;
            expData[k] = 0;
            expOvf[k]  = 1'b0;
         end else if (pending[k]) begin
            if (rdy) pending[k] = 1'b0;
         end else if (v) begin
            total[k] += d;
            cnt[k]++;
            if (cnt[k] == fl[k]) begin
               expData[k] = total[k] % (1 << aw[k]);
               expOvf[k]  = (total[k] >= (1 << aw[k]));
               pending[k] = 1'b1;
               total[k]   = 0;
               cnt[k]     = 0;
            end
         end
      end
      #1;
      for (int k = 0; k < 3; k++) begin
         checkOutput("dout_vld",  k, vldOf(k),  32'(pending[k]));
         checkOutput("dout_data", k, dataOf(k), 32'(expData[k]));
         checkOutput("dout_ovf",  k, ovfOf(k),  32'(expOvf[k]));
      end
   endtask

   // Directed scenarios first, then a randomized stream with occasional resets.
   initial begin
      rst     = 1'b1;
      dinVld  = 1'b0;
      dinData = '0;
      doutRd  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         total[k]   = 0;
         cnt[k]     = 0;
         expData[k] = 0;
         expOvf[k]  = 1'b0;
         pending[k] = 1'b0;
      end

      $display("[TB] reset");
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);

      $display("[TB] basic frame 1,2,3,4");
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, seqA[i], 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);

      $display("[TB] wrap-around 15x4 then 1x4");
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 15, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);

      $display("[TB] gaps in frame");
      for (int i = 0; i < 7; i++) applyStimulus(0, gapV[i][0], gapD[i], 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);

      $display("[TB] backpressure");
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 9, 0);
      for (int i = 0; i < 6; i++) applyStimulus(0, 1, 3, 0);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);

      $display("[TB] reset mid-frame");
      applyStimulus(0, 1, 7, 1);
      applyStimulus(0, 1, 7, 1);
      applyStimulus(1, 1, 7, 1);
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, seqA[i], 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);

      $display("[TB] streaming 3,12,0");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, fl1D[i], 1);
         applyStimulus(0, 1, fl1D[i], 1);
      end
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);

      $display("[TB] randomized stream");
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 59) == 0,
                       $urandom_range(0, 3) != 0,
                       int'($urandom_range(0, 15)),
                       $urandom_range(0, 2) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
